// File: rtl/mem_stream_reader_if.sv
// Bundles the start/read/stream signals of mem_stream_reader.
// slave = the reader block, master = its driver (controller, memory and consumer).
interface mem_stream_reader_if #(
  parameter int DATA = 32,
  parameter int ADDR = 10
);
  logic            start;
  logic [ADDR-1:0] base_addr;
  logic [ADDR:0]   length;
  logic            rd_en;
  logic [ADDR-1:0] rd_addr;
  logic [DATA-1:0] rd_data;
  logic [DATA-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
  logic            done;

  modport slave (
    input  start, base_addr, length, rd_data, out_ready,
    output rd_en, rd_addr, out_data, out_valid, busy, done
  );

  modport master (
    output start, base_addr, length, rd_data, out_ready,
    input  rd_en, rd_addr, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/mem_stream_reader.sv
// Burst reader: issues sequential memory reads (one-cycle read latency) and streams
// the words through a 2-entry FIFO with valid/ready. All state changes on the falling edge.
module mem_stream_reader #(
  parameter int DATA = 32,
  parameter int ADDR = 10
) (
  input logic               clk,
  input logic               rst,
  mem_stream_reader_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;

  state_t          r_state, w_next;
  logic [ADDR-1:0] r_addr;
  logic [ADDR:0]   r_rd_left, r_xfer_left;
  logic            r_inflight, r_done;
  logic [DATA-1:0] r_fifo [2];
  logic            r_wp, r_rp;
  logic [1:0]      r_cnt;

  logic            w_push, w_pop, w_issue, w_launch, w_zero, w_fin;
  logic [2:0]      w_credit;

  assign w_push   = r_inflight;
  assign w_pop    = (r_cnt != 2'd0) && bus.out_ready;
  // Slots committed after this edge; a same-edge pop frees one, which keeps
  // the stream at one word per cycle.
  assign w_credit = {1'b0, r_cnt} + {2'b0, r_inflight} - {2'b0, w_pop};

  always_comb begin
    w_next   = r_state;
    w_issue  = 1'b0;
    w_launch = 1'b0;
    w_zero   = 1'b0;
    w_fin    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (bus.length == '0) begin
            w_zero = 1'b1;
          end else begin
            w_launch = 1'b1;
            w_next   = READ;
          end
        end
      end
      READ: begin
        if (w_credit < 3'd2) begin
          w_issue = 1'b1;
          if (r_rd_left == (ADDR+1)'(1)) w_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_pop && r_xfer_left == (ADDR+1)'(1)) begin
          w_fin  = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(negedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_rd_left   <= '0;
      r_xfer_left <= '0;
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
      r_wp        <= 1'b0;
      r_rp        <= 1'b0;
      r_cnt       <= 2'd0;
      for (int i = 0; i < 2; i++) r_fifo[i] <= '0;
    end else begin
      r_inflight <= w_issue;
      r_done     <= w_zero | w_fin;
      if (w_launch) begin
        r_addr      <= bus.base_addr;
        r_rd_left   <= bus.length;
        r_xfer_left <= bus.length;
      end else begin
        if (w_issue) begin
          r_addr    <= r_addr + ADDR'(1);
          r_rd_left <= r_rd_left - (ADDR+1)'(1);
        end
        if (w_pop) r_xfer_left <= r_xfer_left - (ADDR+1)'(1);
      end
      if (w_push) begin
        r_fifo[r_wp] <= bus.rd_data;
        r_wp         <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign bus.rd_en     = w_issue;
  assign bus.rd_addr   = r_addr;
  assign bus.out_valid = (r_cnt != 2'd0);
  assign bus.out_data  = (r_cnt != 2'd0) ? r_fifo[r_rp] : '0;
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = r_done;
endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader: memory model mem[i]=i, bursts sampled on the
// rising edge (DUT acts on the falling edge), cycle 0 = first sample after the start edge.
module tb_mem_stream_reader;
  localparam int DATA = 32;
  localparam int ADDR = 10;
  localparam int DEPTH = 1 << ADDR;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stream_reader_if #(.DATA(DATA), .ADDR(ADDR)) bus ();
  mem_stream_reader #(.DATA(DATA), .ADDR(ADDR)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [DATA-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = DATA'(i);
  always @(negedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

  int errors = 0;
  int checks = 0;

  logic [DATA-1:0] got [$];
  logic [ADDR-1:0] addrs [$];
  int max_out, done_cnt, first_v, last_x, done_cyc, stab_err;
  logic busy_at_done, busy0;

  task automatic run_burst(input logic [ADDR-1:0] base, input logic [ADDR:0] len,
                           input bit toggle, input int restart_cyc);
    int cyc, issued, xfers;
    bit fin, prev_stall;
    logic [DATA-1:0] prev_data;
    logic [3:0] pat;
    pat = 4'b1001;
    got.delete(); addrs.delete();
    max_out = 0; done_cnt = 0; first_v = -1; last_x = -1; done_cyc = -1;
    stab_err = 0; busy_at_done = 1'b1; busy0 = 1'b0; prev_stall = 1'b0; prev_data = '0;
    @(posedge clk);
    bus.start = 1'b1; bus.base_addr = base; bus.length = len; bus.out_ready = 1'b1;
    @(posedge clk);
    cyc = 0; issued = 0; xfers = 0; fin = 1'b0;
    while (!fin && cyc < 3000) begin
      if (cyc == restart_cyc) begin
        bus.start = 1'b1; bus.base_addr = ADDR'(100); bus.length = (ADDR+1)'(3);
      end else begin
        bus.start = 1'b0;
      end
      bus.out_ready = toggle ? pat[cyc % 4] : 1'b1;
      #1;
      if (cyc == 0) busy0 = bus.busy;
      if (prev_stall && bus.out_data !== prev_data) stab_err++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (bus.rd_en) begin addrs.push_back(bus.rd_addr); issued++; end
      if (bus.out_valid && first_v < 0) first_v = cyc;
      if (bus.out_valid && bus.out_ready) begin got.push_back(bus.out_data); xfers++; last_x = cyc; end
      if (issued - xfers > max_out) max_out = issued - xfers;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = bus.busy; end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 2) fin = 1'b1;
      cyc++;
      @(posedge clk);
    end
    bus.start = 1'b0; bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.base_addr = '0; bus.length = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.rd_en, bus.rd_addr, bus.out_valid, bus.out_data, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rd_en=%b rd_addr=%0d out_valid=%b out_data=%0d busy=%b done=%b, required all 0",
               bus.rd_en, bus.rd_addr, bus.out_valid, bus.out_data, bus.busy, bus.done);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int bad;
    run_burst(ADDR'(5), (ADDR+1)'(4), 1'b0, -1);
    bad = 0;
    for (int i = 0; i < 4; i++) if (i >= got.size() || got[i] !== DATA'(5 + i)) bad++;
    checks++; if (got.size() != 4 || bad != 0) begin errors++; $display("FAIL basic_data: size=%0d bad=%0d, required 4 words 5..8", got.size(), bad); end
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL basic_busy_start: busy=%b required 1", busy0); end
    checks++; if (first_v != 2) begin errors++; $display("FAIL basic_latency: first valid cycle %0d required 2", first_v); end
    checks++; if (last_x != 5) begin errors++; $display("FAIL basic_throughput: last transfer cycle %0d required 5", last_x); end
    checks++; if (done_cyc != 6 || done_cnt != 1) begin errors++; $display("FAIL basic_done: cycle=%0d count=%0d required 6 and 1", done_cyc, done_cnt); end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_end: busy=%b required 0", busy_at_done); end
  endtask

  task automatic test_wrap();
    int bad;
    logic [ADDR-1:0] ea;
    run_burst(ADDR'(1022), (ADDR+1)'(4), 1'b0, -1);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      ea = ADDR'((1022 + i) % DEPTH);
      if (i >= addrs.size() || addrs[i] !== ea) bad++;
    end
    checks++; if (addrs.size() != 4 || bad != 0) begin errors++; $display("FAIL wrap_addr: size=%0d bad=%0d, required 1022,1023,0,1", addrs.size(), bad); end
    bad = 0;
    for (int i = 0; i < 4; i++) if (i >= got.size() || got[i] !== DATA'((1022 + i) % DEPTH)) bad++;
    checks++; if (got.size() != 4 || bad != 0) begin errors++; $display("FAIL wrap_data: size=%0d bad=%0d, required 1022,1023,0,1", got.size(), bad); end
  endtask

  task automatic test_backpressure();
    int bad;
    run_burst(ADDR'(20), (ADDR+1)'(8), 1'b1, -1);
    bad = 0;
    for (int i = 0; i < 8; i++) if (i >= got.size() || got[i] !== DATA'(20 + i)) bad++;
    checks++; if (got.size() != 8 || bad != 0) begin errors++; $display("FAIL bp_data: size=%0d bad=%0d, required 8 words 20..27", got.size(), bad); end
    checks++; if (max_out > 2) begin errors++; $display("FAIL bp_outstanding: max=%0d required <=2", max_out); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL bp_stable: changes=%0d required 0", stab_err); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done: count=%0d required 1", done_cnt); end
  endtask

  task automatic test_zero_length();
    int d, r, b;
    d = 0; r = 0; b = 0;
    @(posedge clk);
    bus.start = 1'b1; bus.base_addr = ADDR'(9); bus.length = '0;
    @(posedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (bus.done) d++;
      if (bus.rd_en) r++;
      if (bus.busy) b++;
      @(posedge clk);
    end
    checks++; if (d != 1) begin errors++; $display("FAIL zero_done: cycles=%0d required 1", d); end
    checks++; if (r != 0 || b != 0) begin errors++; $display("FAIL zero_idle: rd_en cycles=%0d busy cycles=%0d required 0 and 0", r, b); end
  endtask

  task automatic test_mid_reset();
    int cyc, xfers, d;
    @(posedge clk);
    bus.start = 1'b1; bus.base_addr = ADDR'(10); bus.length = (ADDR+1)'(8); bus.out_ready = 1'b1;
    @(posedge clk);
    bus.start = 1'b0;
    cyc = 0; xfers = 0;
    while (xfers < 3 && cyc < 50) begin
      #1;
      if (bus.out_valid && bus.out_ready) xfers++;
      cyc++;
      @(posedge clk);
    end
    checks++; if (xfers != 3) begin errors++; $display("FAIL rst_setup: transfers=%0d required 3", xfers); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.out_valid, bus.busy, bus.rd_en, bus.done} !== 4'b0) begin
      errors++;
      $display("FAIL rst_abort: out_valid=%b busy=%b rd_en=%b done=%b, required all 0",
               bus.out_valid, bus.busy, bus.rd_en, bus.done);
    end
    rst = 1'b0;
    d = 0;
    for (int c = 0; c < 3; c++) begin @(posedge clk); #1; if (bus.done || bus.out_valid) d++; end
    checks++; if (d != 0) begin errors++; $display("FAIL rst_no_done: done/valid cycles=%0d required 0", d); end
    run_burst(ADDR'(0), (ADDR+1)'(2), 1'b0, -1);
    checks++;
    if (got.size() != 2 || got[0] !== DATA'(0) || got[1] !== DATA'(1)) begin
      errors++; $display("FAIL rst_restart: size=%0d, required words 0,1", got.size());
    end
  endtask

  task automatic test_back_to_back_start();
    int bad;
    run_burst(ADDR'(40), (ADDR+1)'(6), 1'b0, 2);
    bad = 0;
    for (int i = 0; i < 6; i++) if (i >= got.size() || got[i] !== DATA'(40 + i)) bad++;
    checks++; if (got.size() != 6 || bad != 0) begin errors++; $display("FAIL restart_data: size=%0d bad=%0d, required 6 words 40..45", got.size(), bad); end
    checks++; if (addrs.size() != 6 || done_cnt != 1) begin errors++; $display("FAIL restart_reads: reads=%0d done=%0d required 6 and 1", addrs.size(), done_cnt); end
  endtask

  task automatic test_full_depth();
    int bad;
    run_burst(ADDR'(700), (ADDR+1)'(DEPTH), 1'b0, -1);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i >= addrs.size() || addrs[i] !== ADDR'((700 + i) % DEPTH)) bad++;
      if (i >= got.size() || got[i] !== DATA'((700 + i) % DEPTH)) bad++;
    end
    checks++; if (addrs.size() != DEPTH || got.size() != DEPTH || bad != 0) begin errors++; $display("FAIL full_depth: reads=%0d words=%0d bad=%0d, required %0d each, 0 bad", addrs.size(), got.size(), bad, DEPTH); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL full_done: count=%0d required 1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_length();
    test_mid_reset();
    test_back_to_back_start();
    test_full_depth();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
